// File: rtl/m_ext_pkg.sv
// Shared definitions for the RV32M scheduler: funct3 encodings, FSM states
// and the architectural special-case constants.
package m_ext_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_MUL,
        ST_WAIT_DIV,
        ST_DRAIN,
        ST_RESP
    } m_ext_state_t;

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic is_div_op(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/m_ext_scheduler_if.sv
// Request/response channel between the execute stage (master) and the
// M-extension scheduler (slave).
interface m_ext_scheduler_if;

    logic        stb_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_1_i;
    logic [31:0] op_2_i;
    logic        flush_i;
    logic [31:0] result_o;
    logic        ack_o;
    logic        busy_o;

    modport master (
        output stb_i, funct3_i, op_1_i, op_2_i, flush_i,
        input  result_o, ack_o, busy_o
    );

    modport slave (
        input  stb_i, funct3_i, op_1_i, op_2_i, flush_i,
        output result_o, ack_o, busy_o
    );

endinterface

// File: rtl/m_ext_special_case.sv
// Combinational detection of RV32M operations whose result is fixed by the
// ISA (divide-by-zero, signed overflow) or trivially zero (zero multiply).
module m_ext_special_case
    import m_ext_pkg::*;
#(
    parameter bit ENABLE_FAST_PATH = 1'b1
) (
    input  logic [2:0]  funct3,
    input  logic [31:0] op_1,
    input  logic [31:0] op_2,
    output logic        is_local,
    output logic [31:0] local_result
);

    // Classify the request; divide special cases are always resolved here.
    always_comb begin
        is_local     = 1'b0;
        local_result = '0;
        if (is_div_op(funct3)) begin
            if (op_2 == '0) begin
                is_local     = 1'b1;
                local_result = funct3[1] ? op_1 : DIV_BY_ZERO_Q;
            end else if (!funct3[0] && (op_1 == INT_MIN) && (op_2 == '1)) begin
                is_local     = 1'b1;
                local_result = funct3[1] ? '0 : INT_MIN;
            end
        end else if (ENABLE_FAST_PATH && ((op_1 == '0) || (op_2 == '0))) begin
            is_local     = 1'b1;
            local_result = '0;
        end
    end

endmodule

// File: rtl/m_ext_scheduler.sv
// RV32M sequencer: decodes funct3, resolves special cases locally and
// otherwise dispatches to the shared multiplier or divider, returning the
// result with a one-cycle ack. Supports flush with drain of an in-flight op.
module m_ext_scheduler
    import m_ext_pkg::*;
#(
    parameter bit ENABLE_FAST_PATH = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    m_ext_scheduler_if.slave   req,

    output logic               mul_stb_o,
    output logic [31:0]        mul_op_1_o,
    output logic [31:0]        mul_op_2_o,
    output logic               mul_op_1_is_signed_o,
    output logic               mul_op_2_is_signed_o,
    output logic               mul_result_upper_o,
    input  logic [31:0]        mul_result_i,
    input  logic               mul_ack_i,

    output logic               div_stb_o,
    output logic [31:0]        div_op_1_o,
    output logic [31:0]        div_op_2_o,
    output logic               div_is_signed_o,
    output logic               div_result_rem_o,
    input  logic [31:0]        div_result_i,
    input  logic               div_ack_i
);

    m_ext_state_t state;
    logic         pending_div;
    logic         is_local;
    logic [31:0]  local_result;

    m_ext_special_case #(
        .ENABLE_FAST_PATH(ENABLE_FAST_PATH)
    ) u_special_case (
        .funct3       (req.funct3_i),
        .op_1         (req.op_1_i),
        .op_2         (req.op_2_i),
        .is_local     (is_local),
        .local_result (local_result)
    );

    // Scheduler FSM with registered outputs; strobes and ack default low
    // so each is a single-cycle pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state                <= ST_IDLE;
            pending_div          <= 1'b0;
            req.result_o         <= '0;
            req.ack_o            <= 1'b0;
            req.busy_o           <= 1'b0;
            mul_stb_o            <= 1'b0;
            mul_op_1_o           <= '0;
            mul_op_2_o           <= '0;
            mul_op_1_is_signed_o <= 1'b0;
            mul_op_2_is_signed_o <= 1'b0;
            mul_result_upper_o   <= 1'b0;
            div_stb_o            <= 1'b0;
            div_op_1_o           <= '0;
            div_op_2_o           <= '0;
            div_is_signed_o      <= 1'b0;
            div_result_rem_o     <= 1'b0;
        end else begin
            mul_stb_o <= 1'b0;
            div_stb_o <= 1'b0;
            req.ack_o <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (req.stb_i && !req.flush_i) begin
                        req.busy_o <= 1'b1;
                        if (is_local) begin
                            req.result_o <= local_result;
                            req.ack_o    <= 1'b1;
                            state        <= ST_RESP;
                        end else if (is_div_op(req.funct3_i)) begin
                            div_op_1_o       <= req.op_1_i;
                            div_op_2_o       <= req.op_2_i;
                            div_is_signed_o  <= !req.funct3_i[0];
                            div_result_rem_o <= req.funct3_i[1];
                            div_stb_o        <= 1'b1;
                            pending_div      <= 1'b1;
                            state            <= ST_WAIT_DIV;
                        end else begin
                            mul_op_1_o           <= req.op_1_i;
                            mul_op_2_o           <= req.op_2_i;
                            mul_op_1_is_signed_o <= (req.funct3_i != F3_MULHU);
                            mul_op_2_is_signed_o <= !req.funct3_i[1];
                            mul_result_upper_o   <= (req.funct3_i != F3_MUL);
                            mul_stb_o            <= 1'b1;
                            pending_div          <= 1'b0;
                            state                <= ST_WAIT_MUL;
                        end
                    end
                end

                ST_WAIT_MUL: begin
                    if (mul_ack_i) begin
                        if (req.flush_i) begin
                            req.busy_o <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            req.result_o <= mul_result_i;
                            req.ack_o    <= 1'b1;
                            state        <= ST_RESP;
                        end
                    end else if (req.flush_i) begin
                        state <= ST_DRAIN;
                    end
                end

                ST_WAIT_DIV: begin
                    if (div_ack_i) begin
                        if (req.flush_i) begin
                            req.busy_o <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            req.result_o <= div_result_i;
                            req.ack_o    <= 1'b1;
                            state        <= ST_RESP;
                        end
                    end else if (req.flush_i) begin
                        state <= ST_DRAIN;
                    end
                end

                // Only the ack of the unit that was started ends the drain.
                ST_DRAIN: begin
                    if (pending_div ? div_ack_i : mul_ack_i) begin
                        req.busy_o <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                ST_RESP: begin
                    req.busy_o <= 1'b0;
                    state      <= ST_IDLE;
                end

                default: begin
                    req.busy_o <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
